life_sequencer: RTL and testbench
=================================

Name: life_sequencer

Overview:
- Run-control FSM for the 16x16 Game of Life board.
- Owns when the board is in switch-driven load mode and when it captures the next generation (one-cycle `advance` strobe).
- Paces generations with a tick divider, supports free-run, pause and single-step.
- Halts automatically on extinction, on a stable pattern, or at a generation limit.
- Sits between the key/switch conditioners and the board register array plus next-generation logic.

Parameters:
- TICK_CYCLES, 25000000: clock cycles per generation in RUN. Must be >= 2.
- MAX_GEN, 0: generation limit. 0 = unlimited. Otherwise HALT after the MAX_GEN-th advance.

Ports:
- Clock  in  1  system clock. All logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- load_mode  in  1  level (sw[9]). 1 = board editable from switches.
- start  in  1  single-cycle pulse, already debounced/edge-detected upstream.
- pause  in  1  single-cycle pulse.
- step  in  1  single-cycle pulse.
- board_cur  in  [15:0][15:0]  current board state.
- board_next  in  [15:0][15:0]  next-generation board from the rule logic.
- load_en  out  1  1 while in LOAD. The board accepts switch edits only when high.
- advance  out  1  registered one-cycle strobe. The board captures board_next on the edge ending this cycle.
- gen_count  out  16  generations advanced since leaving LOAD. Saturates at 16'hFFFF.
- state  out  2  00 LOAD, 01 PAUSE, 10 RUN, 11 HALT.
- halt_cause  out  2  00 none, 01 extinct, 10 stable, 11 max_gen. Holds until LOAD is re-entered.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=LOAD, load_en=1, advance=0, gen_count=0, halt_cause=00, tick_cnt=0.
  - Reset asserted mid-RUN drops any pending advance; advance is 0 in the cycle after Reset.
- load_mode=1 in any state: next state LOAD, with gen_count, halt_cause and tick_cnt cleared and advance=0. Overrides start, pause, step and tick.
- LOAD:
  - load_en=1, start/pause/step ignored.
  - load_mode=0 -> PAUSE next cycle. load_en follows state and drops with it.
- PAUSE:
  - start -> RUN with tick_cnt=0.
  - step -> evaluation this cycle, state stays PAUSE.
  - start and step in the same cycle: start wins, step is dropped.
  - step in the cycle where advance is high: ignored, so the board updates before the next evaluation.
- RUN:
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps to 0.
  - Evaluation happens in the cycle where tick_cnt==TICK_CYCLES-1.
  - pause -> PAUSE with tick_cnt cleared. If pause coincides with the terminal tick, pause wins: no evaluation, no advance.
  - step ignored.
- HALT:
  - start, pause and step ignored; only load_mode exits.
  - advance stays 0.
- Evaluation in cycle T, sampling board_cur/board_next in T, priority order:
  - board_cur all zero -> HALT in T+1, halt_cause=01, no advance.
  - board_next==board_cur -> HALT in T+1, halt_cause=10, no advance.
  - Otherwise:
    - advance=1 during T+1 only; gen_count increments, visible in T+1.
    - If MAX_GEN!=0 and the new gen_count==MAX_GEN: the advance is still issued, state=HALT in T+1, halt_cause=11.
- Width rules:
  - gen_count is 16-bit and saturates at 16'hFFFF; it never wraps.
  - tick_cnt is sized by $clog2(TICK_CYCLES).
- Consecutive RUN evaluations are exactly TICK_CYCLES cycles apart.
- advance never stays high on two consecutive cycles.

Test Plan:
- Reset, then load_mode 1->0, then start, with TICK_CYCLES=4, MAX_GEN=0, blinker pattern -> state 00 then 01 then 10; advance high every 4th cycle; gen_count 1,2,3.
- Empty board in PAUSE, step -> state=11, halt_cause=01, advance never high, gen_count=0.
- Block pattern (board_next==board_cur) in RUN -> HALT at first terminal tick, halt_cause=10, gen_count=0.
- MAX_GEN=3, blinker in RUN -> exactly three advance pulses, state=11 in the cycle of the third pulse, halt_cause=11, gen_count=3.
- pause pulse in the terminal-tick cycle -> no advance, state=01; then start and step in the same cycle -> state=10, no step advance.
- load_mode=1 asserted in the cycle an advance is pending, and Reset pulsed mid-RUN -> next cycle state=00, advance=0, gen_count=0, halt_cause=00, load_en=1.

Source files
------------

// File: rtl/life_sequencer.sv
// Run-control FSM for the 16x16 Game of Life board.
//
// Decides when the board is editable (LOAD) and when it captures the next generation.
// Generations are paced by a tick divider in RUN, or triggered one at a time by step in PAUSE.
// The sequencer halts on its own when the board goes extinct, when the pattern is stable,
// or when the generation limit is reached.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   load_mode_i   level, 1 = board editable from switches
//   start_i       one-cycle pulse: PAUSE -> RUN
//   pause_i       one-cycle pulse: RUN -> PAUSE
//   step_i        one-cycle pulse: single evaluation while in PAUSE
//   board_cur_i   current board
//   board_next_i  next-generation board from the rule logic
//   load_en_o     1 while in LOAD
//   advance_o     registered one-cycle strobe: board captures board_next at the end of it
//   gen_count_o   generations advanced since leaving LOAD, saturating
//   state_o       00 LOAD, 01 PAUSE, 10 RUN, 11 HALT
//   halt_cause_o  00 none, 01 extinct, 10 stable, 11 max_gen
module life_sequencer #(
    parameter int unsigned TICK_CYCLES = 25000000,
    parameter int unsigned MAX_GEN     = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_mode_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               step_i,
    input  logic [15:0][15:0]  board_cur_i,
    input  logic [15:0][15:0]  board_next_i,
    output logic               load_en_o,
    output logic               advance_o,
    output logic [15:0]        gen_count_o,
    output logic [1:0]         state_o,
    output logic [1:0]         halt_cause_o
);

    localparam int unsigned TickW = $clog2(TICK_CYCLES);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        StLoad  = 2'b00,
        StPause = 2'b01,
        StRun   = 2'b10,
        StHalt  = 2'b11
    } state_e;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseExtinct = 2'b01;
    localparam logic [1:0] CauseStable  = 2'b10;
    localparam logic [1:0] CauseMaxGen  = 2'b11;

    state_e           state_q, state_d;
    logic             advance_q, advance_d;
    logic [15:0]      gen_count_q, gen_count_d;
    logic [1:0]       halt_cause_q, halt_cause_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;

    logic        eval;
    logic [15:0] gen_inc;

    assign gen_inc = (gen_count_q == 16'hFFFF) ? gen_count_q : gen_count_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        advance_d    = 1'b0;
        gen_count_d  = gen_count_q;
        halt_cause_d = halt_cause_q;
        tick_cnt_d   = tick_cnt_q;
        eval         = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (!load_mode_i) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (start_i) begin
                    state_d    = StRun;
                    tick_cnt_d = '0;
                end else if (step_i && !advance_q) begin
                    // Skip a step while the board is still capturing the previous generation.
                    eval = 1'b1;
                end
            end
            StRun: begin
                if (pause_i) begin
                    state_d    = StPause;
                    tick_cnt_d = '0;
                end else if (tick_cnt_q == TickLast) begin
                    tick_cnt_d = '0;
                    eval       = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + TickW'(1);
                end
            end
            StHalt: begin
            end
            default: begin
                state_d = StLoad;
            end
        endcase

        if (eval) begin
            if (board_cur_i == '0) begin
                state_d      = StHalt;
                halt_cause_d = CauseExtinct;
            end else if (board_next_i == board_cur_i) begin
                state_d      = StHalt;
                halt_cause_d = CauseStable;
            end else begin
                advance_d   = 1'b1;
                gen_count_d = gen_inc;
                if (MAX_GEN != 0 && {16'd0, gen_inc} == MAX_GEN) begin
                    state_d      = StHalt;
                    halt_cause_d = CauseMaxGen;
                end
            end
        end

        // Load mode overrides every other control input and any pending evaluation.
        if (load_mode_i) begin
            state_d      = StLoad;
            advance_d    = 1'b0;
            gen_count_d  = '0;
            halt_cause_d = CauseNone;
            tick_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StLoad;
            advance_q    <= 1'b0;
            gen_count_q  <= '0;
            halt_cause_q <= CauseNone;
            tick_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            advance_q    <= advance_d;
            gen_count_q  <= gen_count_d;
            halt_cause_q <= halt_cause_d;
            tick_cnt_q   <= tick_cnt_d;
        end
    end

    assign load_en_o    = (state_q == StLoad);
    assign advance_o    = advance_q;
    assign gen_count_o  = gen_count_q;
    assign state_o      = state_q;
    assign halt_cause_o = halt_cause_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with TICK_CYCLES=4. Two instances share all inputs:
// dut has no generation limit, dut_mg halts after its third advance (MAX_GEN=3).
module tb_life_sequencer;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              load_mode_i;
    logic              start_i;
    logic              pause_i;
    logic              step_i;
    logic [15:0][15:0] board_cur_i;
    logic [15:0][15:0] board_next_i;

    logic              load_en_o, mg_load_en_o;
    logic              advance_o, mg_advance_o;
    logic [15:0]       gen_count_o, mg_gen_count_o;
    logic [1:0]        state_o, mg_state_o;
    logic [1:0]        halt_cause_o, mg_halt_cause_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    life_sequencer #(.TICK_CYCLES(4), .MAX_GEN(0)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_mode_i  (load_mode_i),
        .start_i      (start_i),
        .pause_i      (pause_i),
        .step_i       (step_i),
        .board_cur_i  (board_cur_i),
        .board_next_i (board_next_i),
        .load_en_o    (load_en_o),
        .advance_o    (advance_o),
        .gen_count_o  (gen_count_o),
        .state_o      (state_o),
        .halt_cause_o (halt_cause_o)
    );

    life_sequencer #(.TICK_CYCLES(4), .MAX_GEN(3)) dut_mg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_mode_i  (load_mode_i),
        .start_i      (start_i),
        .pause_i      (pause_i),
        .step_i       (step_i),
        .board_cur_i  (board_cur_i),
        .board_next_i (board_next_i),
        .load_en_o    (mg_load_en_o),
        .advance_o    (mg_advance_o),
        .gen_count_o  (mg_gen_count_o),
        .state_o      (mg_state_o),
        .halt_cause_o (mg_halt_cause_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_blinker();
        board_cur_i     = '0;
        board_next_i    = '0;
        board_cur_i[7]  = 16'h01C0;
        board_next_i[6] = 16'h0080;
        board_next_i[7] = 16'h0080;
        board_next_i[8] = 16'h0080;
    endtask

    task automatic set_block();
        board_cur_i     = '0;
        board_cur_i[7]  = 16'h0180;
        board_cur_i[8]  = 16'h0180;
        board_next_i    = board_cur_i;
    endtask

    // load_mode high for one cycle then low: ends in PAUSE with counters cleared.
    task automatic reload();
        load_mode_i = 1'b1;
        cyc();
        load_mode_i = 1'b0;
        cyc();
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, ".state"},   32'(state_o),      32'd0);
        check_eq({tag, ".load_en"}, 32'(load_en_o),    32'd1);
        check_eq({tag, ".advance"}, 32'(advance_o),    32'd0);
        check_eq({tag, ".gen"},     32'(gen_count_o),  32'd0);
        check_eq({tag, ".cause"},   32'(halt_cause_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        load_mode_i = 1'b1;
        start_i     = 1'b0;
        pause_i     = 1'b0;
        step_i      = 1'b0;
        set_blinker();
        cyc();
        cyc();
        check_cleared("reset");

        // LOAD -> PAUSE -> RUN, blinker free-run.
        rst_i       = 1'b0;
        load_mode_i = 1'b0;
        cyc();
        check_eq("pause.state",   32'(state_o),   32'd1);
        check_eq("pause.load_en", 32'(load_en_o), 32'd0);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        check_eq("run.state", 32'(state_o), 32'd2);
        for (int i = 0; i < 16; i++) begin
            cyc();
            check_eq("run.adv",  32'(advance_o),   32'((i % 4) == 3));
            check_eq("run.gen",  32'(gen_count_o), 32'((i + 1) / 4));
            check_eq("mg.adv",   32'(mg_advance_o), 32'((i % 4) == 3 && i <= 11));
            check_eq("mg.gen",   32'(mg_gen_count_o), 32'((i >= 11) ? 3 : (i + 1) / 4));
            check_eq("mg.state", 32'(mg_state_o), (i >= 11) ? 32'd3 : 32'd2);
            check_eq("mg.cause", 32'(mg_halt_cause_o), (i >= 11) ? 32'd3 : 32'd0);
        end

        // Pause coinciding with the terminal tick: no advance.
        cyc();
        cyc();
        cyc();
        check_eq("pre_pause.adv", 32'(advance_o), 32'd0);
        pause_i = 1'b1;
        cyc();
        pause_i = 1'b0;
        check_eq("term_pause.state", 32'(state_o),   32'd1);
        check_eq("term_pause.adv",   32'(advance_o), 32'd0);
        check_eq("term_pause.gen",   32'(gen_count_o), 32'd4);
        check_eq("mg_halt_pause",    32'(mg_state_o), 32'd3);
        cyc();
        check_eq("term_pause.adv2",  32'(advance_o), 32'd0);

        // Start and step together: start wins, no step advance.
        start_i = 1'b1;
        step_i  = 1'b1;
        cyc();
        start_i = 1'b0;
        step_i  = 1'b0;
        check_eq("start_step.state", 32'(state_o),   32'd2);
        check_eq("start_step.adv",   32'(advance_o), 32'd0);
        check_eq("start_step.gen",   32'(gen_count_o), 32'd4);
        check_eq("mg_halt_start",    32'(mg_state_o), 32'd3);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("restart.adv", 32'(advance_o), 32'(i == 3));
        end
        check_eq("restart.gen", 32'(gen_count_o), 32'd5);

        // load_mode in the cycle an evaluation is pending.
        cyc();
        cyc();
        cyc();
        load_mode_i = 1'b1;
        cyc();
        check_cleared("load_override");
        check_eq("mg_load.state", 32'(mg_state_o),      32'd0);
        check_eq("mg_load.cause", 32'(mg_halt_cause_o), 32'd0);
        check_eq("mg_load.gen",   32'(mg_gen_count_o),  32'd0);
        load_mode_i = 1'b0;
        cyc();

        // Empty board, step in PAUSE -> extinct.
        board_cur_i  = '0;
        board_next_i = '0;
        step_i = 1'b1;
        cyc();
        step_i = 1'b0;
        check_eq("extinct.state", 32'(state_o),      32'd3);
        check_eq("extinct.cause", 32'(halt_cause_o), 32'd1);
        check_eq("extinct.adv",   32'(advance_o),    32'd0);
        check_eq("extinct.gen",   32'(gen_count_o),  32'd0);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        check_eq("halt_start.state", 32'(state_o), 32'd3);
        check_eq("halt_start.adv",   32'(advance_o), 32'd0);

        // Step held for three cycles: the middle one lands on advance and is ignored.
        reload();
        set_blinker();
        step_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("step.adv",   32'(advance_o),   32'(i != 1));
            check_eq("step.gen",   32'(gen_count_o), (i == 2) ? 32'd2 : 32'd1);
            check_eq("step.state", 32'(state_o),     32'd1);
        end
        step_i = 1'b0;

        // Block pattern in RUN -> stable at the first terminal tick.
        reload();
        set_block();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("stable.state", 32'(state_o), (i == 3) ? 32'd3 : 32'd2);
            check_eq("stable.adv",   32'(advance_o), 32'd0);
        end
        check_eq("stable.cause", 32'(halt_cause_o), 32'd2);
        check_eq("stable.gen",   32'(gen_count_o),  32'd0);

        // Reset mid-RUN with an evaluation pending.
        reload();
        set_blinker();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        check_eq("pre_rst.gen", 32'(gen_count_o), 32'd1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        load_mode_i = 1'b1;
        check_cleared("mid_run_reset");
        cyc();
        check_eq("post_rst.adv", 32'(advance_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
